// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM state type and byte-framing constant for the instruction-memory loader.
package loader_pkg;
    typedef enum logic [1:0] {S_HDR, S_DATA, S_LAST, S_DONE} ldr_state_t;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus inst_mem write port.
//   rx_valid/rx_data : byte source -> loader
//   rx_ready         : loader -> byte source
//   imem_we/addr/wdata : loader -> inst_mem write port
//   master = source/memory side, slave = loader side
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    modport master (output rx_valid, rx_data, input rx_ready, imem_we, imem_addr, imem_wdata);
    modport slave  (input rx_valid, rx_data, output rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/byte_packer.sv
// byte_packer: assembles accepted bytes little-endian into 32-bit words.
//   clk, reset  : clock, synchronous active-high reset
//   clr         : drop any partial word
//   in_valid    : a byte is accepted this cycle
//   in_data     : byte value
//   word_valid  : combinational pulse on the 4th byte of a word
//   word        : completed word, valid with word_valid
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  cnt;
    logic [23:0] low;
    assign word_valid = in_valid && cnt == 2'(BYTES_PER_WORD - 1);
    assign word = {in_data, low};
    // Shifting right leaves byte 0 in [7:0] once three bytes have arrived.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
            low <= '0;
        end else if (in_valid) begin
            cnt <= cnt + 2'd1;
            low <= {in_data, low[23:8]};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer streaming a counted little-endian image into inst_mem.
//   clk, reset    : clock, synchronous active-high reset
//   start         : abort/restart from the header
//   bus           : byte stream in, inst_mem write port out
//   core_reset    : holds pc/reg_file in reset until the image is written
//   load_done     : image written, core released
//   load_err      : header count exceeds DEPTH (sticky until start/reset)
//   words_loaded  : words actually written, saturates at DEPTH
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    imem_loader_if.slave     bus,
    output logic             core_reset,
    output logic             load_done,
    output logic             load_err,
    output logic [CNT_W-1:0] words_loaded
);
    ldr_state_t  state, state_nxt;
    logic [31:0] word_total, word_idx, word;
    logic        accept, word_valid, hdr_word, data_word, wr;
    assign bus.rx_ready = !reset && (state == S_HDR || state == S_DATA);
    // start has priority: a byte offered on the start edge is discarded.
    assign accept    = bus.rx_valid && bus.rx_ready && !start;
    assign hdr_word  = state == S_HDR && word_valid;
    assign data_word = state == S_DATA && word_valid;
    // Words past DEPTH are consumed but never written, so the address never wraps.
    assign wr        = data_word && word_idx < 32'(DEPTH);
    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clr        (start),
        .in_valid   (accept),
        .in_data    (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );
    always_comb begin
        state_nxt = state;
        if (start) state_nxt = S_HDR;
        else case (state)
            S_HDR:   if (word_valid) state_nxt = (word == 32'd0) ? S_DONE : S_DATA;
            S_DATA:  if (word_valid && word_idx == word_total - 32'd1) state_nxt = S_LAST;
            S_LAST:  state_nxt = S_DONE;
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_HDR;
            word_total     <= '0;
            word_idx       <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_reset     <= 1'b1;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
            words_loaded   <= '0;
        end else begin
            state       <= state_nxt;
            // Registered from the next state so release lands the cycle after the final strobe.
            load_done   <= state_nxt == S_DONE;
            core_reset  <= state_nxt != S_DONE;
            bus.imem_we <= wr;
            if (wr) begin
                bus.imem_addr  <= word_idx << 2;
                bus.imem_wdata <= word;
            end
            if (start) begin
                word_idx     <= '0;
                words_loaded <= '0;
                load_err     <= 1'b0;
            end else begin
                if (hdr_word) begin
                    word_total <= word;
                    load_err   <= word > 32'(DEPTH);
                end
                if (data_word) word_idx <= word_idx + 32'd1;
                if (wr) words_loaded <= words_loaded + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives two loaders (DEPTH 256 and DEPTH 4) with the same byte stream and checks both against an image model.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       cr0, ld0, le0, cr1, ld1, le1;
    logic [8:0] wl0;
    logic [2:0] wl1;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int checks = 0;
    int errors = 0;

    imem_loader_if bus0 ();
    imem_loader_if bus1 ();
    assign bus0.rx_valid = rx_valid;
    assign bus0.rx_data  = rx_data;
    assign bus1.rx_valid = rx_valid;
    assign bus1.rx_data  = rx_data;

    imem_loader #(.DEPTH(256)) u0 (
        .clk(clk), .reset(reset), .start(start), .bus(bus0),
        .core_reset(cr0), .load_done(ld0), .load_err(le0), .words_loaded(wl0)
    );
    imem_loader #(.DEPTH(4)) u1 (
        .clk(clk), .reset(reset), .start(start), .bus(bus1),
        .core_reset(cr1), .load_done(ld1), .load_err(le1), .words_loaded(wl1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus0.imem_we) q0.push_back({bus0.imem_addr, bus0.imem_wdata});
        if (bus1.imem_we) q1.push_back({bus1.imem_addr, bus1.imem_wdata});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!bus0.rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL send_byte: rx_ready=%0b after 20 cycles, required 1", bus0.rx_ready);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus0.rx_ready, bus0.imem_we, cr0, ld0, le0, wl0} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0}
            || bus0.imem_addr !== 32'd0 || bus0.imem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_vals: rdy=%0b we=%0b cr=%0b ld=%0b le=%0b wl=%0d addr=%h data=%h, required 0 0 1 0 0 0 0 0",
                     bus0.rx_ready, bus0.imem_we, cr0, ld0, le0, wl0, bus0.imem_addr, bus0.imem_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus0.rx_ready !== 1'b1 || bus1.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: rx_ready=%0b/%0b required 1/1", bus0.rx_ready, bus1.rx_ready);
        end
    endtask

    task automatic test_image(input string name, input int total, input int gap, input bit rnd, input bit restart);
        logic [7:0]  img[$];
        logic [31:0] wrd[$];
        int exp0, exp1;
        if (restart) pulse_start();
        q0.delete();
        q1.delete();
        for (int i = 0; i < total; i++) wrd.push_back(rnd ? 32'($urandom) : (i == 0 ? 32'h00500093 : 32'h00A00113));
        for (int i = 0; i < 4; i++) img.push_back(8'(total >> (8 * i)));
        foreach (wrd[i]) for (int k = 0; k < 4; k++) img.push_back(wrd[i][8*k +: 8]);
        exp0 = total < 256 ? total : 256;
        exp1 = total < 4 ? total : 4;
        foreach (img[i]) begin
            send_byte(img[i], gap);
            if (i == 3) begin
                checks++;
                if (le0 !== (total > 256) || le1 !== (total > 4)) begin
                    errors++;
                    $display("FAIL %s load_err: %0b/%0b required %0b/%0b", name, le0, le1, total > 256, total > 4);
                end
            end
        end
        if (total > 0) begin
            checks++;
            if (bus0.imem_we !== 1'b1 || bus1.imem_we !== (total <= 4) || ld0 !== 1'b0 || cr0 !== 1'b1) begin
                errors++;
                $display("FAIL %s last_strobe: we=%0b/%0b ld=%0b cr=%0b required 1/%0b 0 1",
                         name, bus0.imem_we, bus1.imem_we, ld0, cr0, total <= 4);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (ld0 !== 1'b1 || cr0 !== 1'b0 || ld1 !== 1'b1 || cr1 !== 1'b0 || bus0.rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done: ld=%0b/%0b cr=%0b/%0b rdy=%0b required 1/1 0/0 0", name, ld0, ld1, cr0, cr1, bus0.rx_ready);
        end
        checks++;
        if (wl0 !== 9'(exp0) || wl1 !== 3'(exp1)) begin
            errors++;
            $display("FAIL %s words_loaded: %0d/%0d required %0d/%0d", name, wl0, wl1, exp0, exp1);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != exp0 || q1.size() != exp1) begin
            errors++;
            $display("FAIL %s strobe_count: %0d/%0d required %0d/%0d", name, q0.size(), q1.size(), exp0, exp1);
        end
        for (int i = 0; i < exp0 && i < q0.size(); i++) begin
            checks++;
            if (q0[i] !== {32'(4 * i), wrd[i]}) begin
                errors++;
                $display("FAIL %s write0[%0d]: addr/data %h required %h", name, i, q0[i], {32'(4 * i), wrd[i]});
            end
        end
        for (int i = 0; i < exp1 && i < q1.size(); i++) begin
            checks++;
            if (q1[i] !== {32'(4 * i), wrd[i]}) begin
                errors++;
                $display("FAIL %s write1[%0d]: addr/data %h required %h", name, i, q1[i], {32'(4 * i), wrd[i]});
            end
        end
    endtask

    task automatic test_start_abort();
        logic [7:0] pre[$] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        pulse_start();
        q0.delete();
        foreach (pre[i]) send_byte(pre[i], 0);
        @(negedge clk);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h02;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        #1;
        checks++;
        if (bus0.rx_ready !== 1'b1 || cr0 !== 1'b1 || ld0 !== 1'b0 || wl0 !== 9'd0) begin
            errors++;
            $display("FAIL abort_state: rdy=%0b cr=%0b ld=%0b wl=%0d required 1 1 0 0", bus0.rx_ready, cr0, ld0, wl0);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL abort_no_strobe: %0d strobes required 0", q0.size());
        end
        test_image("after_abort", 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] pre[$] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
        pulse_start();
        foreach (pre[i]) send_byte(pre[i], 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus0.rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready: rx_ready=%0b required 0", bus0.rx_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus0.rx_ready, bus0.imem_we, cr0, ld0, le0, wl0} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0}
            || bus0.imem_addr !== 32'd0 || bus0.imem_wdata !== 32'd0 || wl1 !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_vals: rdy=%0b we=%0b cr=%0b ld=%0b le=%0b wl=%0d addr=%h data=%h, required 0 0 1 0 0 0 0 0",
                     bus0.rx_ready, bus0.imem_we, cr0, ld0, le0, wl0, bus0.imem_addr, bus0.imem_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus0.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_release: rx_ready=%0b required 1", bus0.rx_ready);
        end
        test_image("after_reset", 2, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) test_image("random", int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_image("basic", 2, 0, 1'b0, 1'b1);
        test_image("empty", 0, 0, 1'b0, 1'b1);
        test_image("sparse", 2, 2, 1'b0, 1'b1);
        test_image("overflow", 6, 0, 1'b1, 1'b1);
        test_start_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
